arm_data_mem_responder: RTL and testbench
=========================================

Name: arm_data_mem_responder

Overview:
- Slave end of the pipelined ARM CPU's data-memory port: services the CPU's address, write-data, write-enable and read-data signals.
- Decodes each access to word-addressed RAM or a small MMIO block.
- MMIO block: free-running timer with compare, sticky status register, and a byte-wide debug-TX FIFO drained by an external ready/valid consumer.
- Sits beside the CPU at SoC top level; the CPU's Memory stage samples read data in the same cycle it presents the address.

Parameters:
BusWidth, 32, data/address width
RamDepth, 64, RAM words (power of 2, >= 4)
FifoDepth, 4, debug-TX FIFO entries (power of 2, >= 2)

Ports:
i_CLK  in  1  clock, rising edge
i_NRESET  in  1  reset, asynchronous, active-low
i_Mem_Write  in  1  write strobe for current access
i_Addr  in  BusWidth  byte address from CPU
i_Write_Data  in  BusWidth  store data
o_Read_Data  out  BusWidth  load data, combinational from i_Addr and current state
o_Dbg_Valid  out  1  FIFO non-empty
o_Dbg_Data  out  8  FIFO head byte
i_Dbg_Ready  in  1  consumer accepts head this cycle

Behaviour:
- One clock; i_NRESET is asynchronous, active-low.
- Reset values: timer count 0, compare 0xFFFFFFFF, status bits 0, FIFO empty (read/write pointers 0). o_Dbg_Valid=0, o_Dbg_Data=0. RAM is not reset.
- Address decode uses i_Addr[1:0]=ignored (word accesses only):
  - RAM: i_Addr < 4*RamDepth; index = i_Addr[log2(RamDepth)+1:2].
  - 0xFFFF0000 TIMER_COUNT: R/W.
  - 0xFFFF0004 TIMER_CMP: R/W.
  - 0xFFFF0008 STATUS: R; W1C on bits 2,3.
  - 0xFFFF000C DBG_TX: write-only; reads return 0.
  - Anything else: read 0, write ignored.
- Reads: zero latency, combinational. Writes: committed on the rising edge while i_Mem_Write=1. A read of a location written in the same cycle returns the old value.
- Timer:
  - Count increments by 1 every cycle and wraps 0xFFFFFFFF->0.
  - A TIMER_COUNT write loads i_Write_Data and takes priority over the increment.
  - When the pre-increment count equals compare, STATUS[2] (match) sets on that edge.
- STATUS bits:
  - [0] FIFO empty (live).
  - [1] FIFO full (live).
  - [2] timer match, sticky.
  - [3] TX overflow, sticky.
  - [31:4] read 0.
  - Writing 1 clears bit 2/3. A set event in the same cycle beats the clear.
- Debug FIFO:
  - A write to DBG_TX pushes i_Write_Data[7:0] when not full.
  - If full (judged on registered state, before any same-cycle pop), the byte is dropped and STATUS[3] sets.
  - Pop when o_Dbg_Valid && i_Dbg_Ready.
  - Push and pop in the same cycle on a non-empty, non-full FIFO keeps the occupancy unchanged.
  - Pointers wrap modulo FifoDepth. Occupancy counter width is log2(FifoDepth)+1.
  - o_Dbg_Data = head entry when non-empty, else 0. o_Dbg_Data must stay stable while o_Dbg_Valid=1 and i_Dbg_Ready=0.
- Reset mid-operation: pointers, occupancy, timer and status return to reset values immediately. Queued bytes are lost. RAM contents are preserved.

Test Plan:
- RAM: write 0xDEADBEEF @0x10, then write 0x12345678 @0x14, then read 0x10 and 0x13 -> both return 0xDEADBEEF; read 0x14 -> 0x12345678; read 0x200 (unmapped) -> 0.
- Timer: write TIMER_COUNT=5, read it next cycle -> 6. Write CMP=10 -> STATUS[2]=1 from the edge after count was 10. Write STATUS=0x4 -> bit 2 cleared. Write COUNT=0xFFFFFFFF -> reads 0 two cycles later.
- FIFO fill: i_Dbg_Ready=0, write 0x41,0x42,0x43,0x44,0x45 to DBG_TX -> STATUS reads 0x0A (full + overflow), o_Dbg_Data=0x41 stable. Raise ready -> 0x41..0x44 drain in order, then o_Dbg_Valid=0, STATUS[0]=1. 0x45 never appears.
- Simultaneous: FIFO holds 2 bytes, ready=1, write 0x55 -> occupancy stays 2. Full FIFO with ready=1 plus push -> byte dropped and STATUS[3]=1.
- Priority: timer match edge coincides with a STATUS W1C of bit 2 -> bit 2 reads 1 afterwards.
- Reset: assert i_NRESET low mid-drain without a clock edge -> o_Dbg_Valid=0 at once, STATUS=0x1. A RAM word written before reset still reads back its value.

Source files
------------

// File: rtl/arm_data_mem_responder.sv
// arm_data_mem_responder: CPU data-memory slave with word RAM, timer, status and debug-TX FIFO
module arm_data_mem_responder #(
  parameter int BusWidth  = 32,
  parameter int RamDepth  = 64,
  parameter int FifoDepth = 4
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_Mem_Write,
  input  logic [BusWidth-1:0] i_Addr,
  input  logic [BusWidth-1:0] i_Write_Data,
  output logic [BusWidth-1:0] o_Read_Data,
  output logic                o_Dbg_Valid,
  output logic [7:0]          o_Dbg_Data,
  input  logic                i_Dbg_Ready
);
  localparam int RA = $clog2(RamDepth);
  localparam int FA = $clog2(FifoDepth);
  localparam logic [BusWidth-1:0] A_CNT = BusWidth'(32'hFFFF0000);
  localparam logic [BusWidth-1:0] A_CMP = BusWidth'(32'hFFFF0004);
  localparam logic [BusWidth-1:0] A_ST  = BusWidth'(32'hFFFF0008);
  localparam logic [BusWidth-1:0] A_TX  = BusWidth'(32'hFFFF000C);

  logic [BusWidth-1:0] ram_q [RamDepth];
  logic [7:0]          fifo_q [FifoDepth];
  logic [BusWidth-1:0] timer_q, timer_d, cmp_q, cmp_d;
  logic                match_q, match_d, ovf_q, ovf_d;
  logic [FA-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FA:0]         cnt_q, cnt_d;
  logic [BusWidth-1:0] addr_w, status;
  logic                is_ram, wr_cnt, wr_cmp, wr_st, wr_tx, empty, full, push, pop;

  assign addr_w = {i_Addr[BusWidth-1:2], 2'b00};
  assign is_ram = i_Addr < BusWidth'(4 * RamDepth);
  assign wr_cnt = i_Mem_Write && addr_w == A_CNT;
  assign wr_cmp = i_Mem_Write && addr_w == A_CMP;
  assign wr_st  = i_Mem_Write && addr_w == A_ST;
  assign wr_tx  = i_Mem_Write && addr_w == A_TX;
  assign empty  = cnt_q == '0;
  assign full   = cnt_q == (FA+1)'(FifoDepth);
  // Overflow is judged on registered fullness, so a same-cycle pop never makes room for a push
  assign push   = wr_tx && !full;
  assign pop    = !empty && i_Dbg_Ready;
  assign status = {{(BusWidth-4){1'b0}}, ovf_q, match_q, full, empty};

  assign o_Dbg_Valid = !empty;
  assign o_Dbg_Data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign o_Read_Data = is_ram          ? ram_q[i_Addr[RA+1:2]] :
                       addr_w == A_CNT ? timer_q :
                       addr_w == A_CMP ? cmp_q :
                       addr_w == A_ST  ? status : '0;

  // Next-state for timer, sticky status bits and FIFO bookkeeping; set events beat W1C clears
  always_comb begin
    timer_d  = wr_cnt ? i_Write_Data : timer_q + BusWidth'(1);
    cmp_d    = wr_cmp ? i_Write_Data : cmp_q;
    match_d  = (timer_q == cmp_q) | (match_q & ~(wr_st & i_Write_Data[2]));
    ovf_d    = (wr_tx & full) | (ovf_q & ~(wr_st & i_Write_Data[3]));
    wr_ptr_d = wr_ptr_q + FA'(push);
    rd_ptr_d = rd_ptr_q + FA'(pop);
    cnt_d    = cnt_q + (FA+1)'(push) - (FA+1)'(pop);
  end

  // Control state register; RAM and FIFO storage live outside reset
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      timer_q  <= '0;
      cmp_q    <= '1;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Word RAM and FIFO storage writes, contents preserved across reset
  always_ff @(posedge i_CLK) begin
    if (i_Mem_Write && is_ram) ram_q[i_Addr[RA+1:2]] <= i_Write_Data;
    if (push) fifo_q[wr_ptr_q] <= i_Write_Data[7:0];
  end
endmodule

// File: tb/tb_arm_data_mem_responder.sv
// tb_arm_data_mem_responder: directed table and sequence checks for arm_data_mem_responder
module tb_arm_data_mem_responder;
  localparam logic [31:0] CNT = 32'hFFFF0000, CMP = 32'hFFFF0004, ST = 32'hFFFF0008, TX = 32'hFFFF000C;

  logic        i_CLK = 0, i_NRESET = 0, i_Mem_Write = 0, i_Dbg_Ready = 0;
  logic [31:0] i_Addr = 0, i_Write_Data = 0, o_Read_Data;
  logic        o_Dbg_Valid;
  logic [7:0]  o_Dbg_Data;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk;
    logic [31:0] rd;
    logic        v;
    logic [7:0]  d;
  } vec_t;
  vec_t tbl[$];

  arm_data_mem_responder dut (
    .i_CLK(i_CLK), .i_NRESET(i_NRESET), .i_Mem_Write(i_Mem_Write), .i_Addr(i_Addr),
    .i_Write_Data(i_Write_Data), .o_Read_Data(o_Read_Data), .o_Dbg_Valid(o_Dbg_Valid),
    .o_Dbg_Data(o_Dbg_Data), .i_Dbg_Ready(i_Dbg_Ready)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rdy,
                     input logic c, input logic [31:0] rd, input logic v, input logic [7:0] d);
    tbl.push_back('{we, addr, wd, rdy, c, rd, v, d});
  endtask

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_Mem_Write = 1; i_Addr = a; i_Write_Data = d;
    step();
    i_Mem_Write = 0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    i_Addr = a;
    #1;
    chk(name, o_Read_Data, exp);
  endtask

  initial begin
    // RAM: write, aliasing low address bits, same-cycle old value, last word, first unmapped
    add(1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 0);
    add(1, 32'h14,  32'h12345678, 0, 0, 0, 0, 0);
    add(0, 32'h10,  0, 0, 1, 32'hDEADBEEF, 0, 0);
    add(0, 32'h13,  0, 0, 1, 32'hDEADBEEF, 0, 0);
    add(0, 32'h14,  0, 0, 1, 32'h12345678, 0, 0);
    add(0, 32'h200, 0, 0, 1, 32'h0, 0, 0);
    add(1, 32'h10,  32'h0BADF00D, 0, 1, 32'hDEADBEEF, 0, 0);
    add(0, 32'h10,  0, 0, 1, 32'h0BADF00D, 0, 0);
    add(1, 32'hFC,  32'hA5A5A5A5, 0, 0, 0, 0, 0);
    add(0, 32'hFC,  0, 0, 1, 32'hA5A5A5A5, 0, 0);
    add(0, 32'h100, 0, 0, 1, 32'h0, 0, 0);
    // FIFO fill past full with ready low, head stays stable
    add(1, TX, 32'h41, 0, 1, 0, 0, 8'h00);
    add(1, TX, 32'h42, 0, 1, 0, 1, 8'h41);
    add(1, TX, 32'h43, 0, 1, 0, 1, 8'h41);
    add(1, TX, 32'h44, 0, 1, 0, 1, 8'h41);
    add(1, TX, 32'h45, 0, 1, 0, 1, 8'h41);
    add(0, ST, 0, 0, 1, 32'h0A, 1, 8'h41);
    add(0, ST, 0, 0, 1, 32'h0A, 1, 8'h41);
    // Drain in order; the overflowed byte never shows up
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h41);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h42);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h43);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h44);
    add(0, ST, 0, 1, 1, 32'h09, 0, 8'h00);
    add(1, ST, 32'h8, 1, 1, 32'h09, 0, 8'h00);
    add(0, ST, 0, 1, 1, 32'h01, 0, 8'h00);
    // Simultaneous push and pop with two queued keeps occupancy at two
    add(1, TX, 32'h61, 0, 1, 0, 0, 8'h00);
    add(1, TX, 32'h62, 0, 1, 0, 1, 8'h61);
    add(1, TX, 32'h55, 1, 1, 0, 1, 8'h61);
    add(0, ST, 0, 0, 1, 32'h00, 1, 8'h62);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h62);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h55);
    add(0, ST, 0, 1, 1, 32'h01, 0, 8'h00);
    // Full FIFO with ready high plus push: byte dropped, overflow set
    add(1, TX, 32'h71, 0, 1, 0, 0, 8'h00);
    add(1, TX, 32'h72, 0, 1, 0, 1, 8'h71);
    add(1, TX, 32'h73, 0, 1, 0, 1, 8'h71);
    add(1, TX, 32'h74, 0, 1, 0, 1, 8'h71);
    add(0, ST, 0, 0, 1, 32'h02, 1, 8'h71);
    add(1, TX, 32'h75, 1, 1, 0, 1, 8'h71);
    add(0, ST, 0, 0, 1, 32'h08, 1, 8'h72);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h72);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h73);
    add(0, 32'h200, 0, 1, 1, 0, 1, 8'h74);
    add(1, ST, 32'h8, 0, 1, 32'h09, 0, 8'h00);
    add(0, ST, 0, 0, 1, 32'h01, 0, 8'h00);

    // Reset state
    #12;
    rd("rst_count", CNT, 32'h0);
    rd("rst_cmp", CMP, 32'hFFFFFFFF);
    rd("rst_status", ST, 32'h1);
    chk("rst_valid", {31'b0, o_Dbg_Valid}, 32'h0);
    chk("rst_data", {24'b0, o_Dbg_Data}, 32'h0);
    @(negedge i_CLK);
    i_NRESET = 1;
    step();

    foreach (tbl[i]) begin
      i_Mem_Write = tbl[i].we; i_Addr = tbl[i].addr; i_Write_Data = tbl[i].wd; i_Dbg_Ready = tbl[i].rdy;
      #1;
      if (tbl[i].chk) chk($sformatf("vec%0d_rd", i), o_Read_Data, tbl[i].rd);
      chk($sformatf("vec%0d_valid", i), {31'b0, o_Dbg_Valid}, {31'b0, tbl[i].v});
      chk($sformatf("vec%0d_data", i), {24'b0, o_Dbg_Data}, {24'b0, tbl[i].d});
      step();
    end
    i_Mem_Write = 0; i_Dbg_Ready = 0;

    // Timer load, increment and compare match
    wr(CNT, 32'd5);
    rd("cnt_loaded", CNT, 32'd5);
    wr(CMP, 32'd10);
    rd("cnt_next", CNT, 32'd6);
    repeat (4) step();
    rd("cnt_at_cmp", CNT, 32'd10);
    rd("st_before_match", ST, 32'h1);
    step();
    rd("st_match", ST, 32'h5);
    wr(ST, 32'h4);
    rd("st_w1c", ST, 32'h1);
    // Match edge coinciding with W1C of bit 2: set wins
    wr(CNT, 32'd8);
    step();
    step();
    rd("cnt_pre_prio", CNT, 32'd10);
    wr(ST, 32'h4);
    rd("st_prio", ST, 32'h5);
    wr(ST, 32'h4);
    // Timer wrap
    wr(CNT, 32'hFFFFFFFF);
    rd("cnt_max", CNT, 32'hFFFFFFFF);
    step();
    rd("cnt_wrap", CNT, 32'h0);

    // Asynchronous reset mid-drain
    wr(TX, 32'h81);
    wr(TX, 32'h82);
    i_Dbg_Ready = 1;
    step();
    chk("pre_rst_data", {24'b0, o_Dbg_Data}, 32'h82);
    #2;
    i_NRESET = 0;
    #1;
    chk("arst_valid", {31'b0, o_Dbg_Valid}, 32'h0);
    chk("arst_data", {24'b0, o_Dbg_Data}, 32'h0);
    rd("arst_status", ST, 32'h1);
    rd("arst_count", CNT, 32'h0);
    rd("arst_ram", 32'h14, 32'h12345678);
    i_Dbg_Ready = 0;
    @(negedge i_CLK);
    i_NRESET = 1;
    step();
    rd("post_rst_ram", 32'h10, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
